// File: rtl/tqvp_capture_pkg.sv
// rtl/tqvp_capture_pkg.sv - register map and bit positions for the byte capture peripheral
package tqvp_capture_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_DIV    = 4'h1;
  localparam logic [3:0] ADDR_DATA   = 4'h2;
  localparam logic [3:0] ADDR_STATUS = 4'h3;
  localparam logic [3:0] ADDR_TS     = 4'h4;

  localparam int EN_BIT   = 0;
  localparam int MODE_BIT = 1;
  localparam int CLR_BIT  = 2;

  localparam int ST_EMPTY_BIT = 4;
  localparam int ST_FULL_BIT  = 5;
  localparam int ST_OVF_BIT   = 6;

  localparam int UO_NEMPTY_BIT = 0;
  localparam int UO_FULL_BIT   = 1;
  localparam int UO_OVF_BIT    = 2;

endpackage

// File: rtl/tqvp_sync_fifo.sv
// rtl/tqvp_sync_fifo.sv - small synchronous FIFO with flush, push-while-full-and-popping allowed
module tqvp_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when an entry leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Entry storage; contents beyond the pointers are don't-care so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !clr) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/tqvp_byte_capture.sv
// rtl/tqvp_byte_capture.sv - PMOD sampler feeding a FIFO on the TinyQV byte bus; TQVP_CAPTURE_TIMESTAMP_EN adds per-entry timestamps
module tqvp_byte_capture
  import tqvp_capture_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam int PTR_W = $clog2(DEPTH);
`ifdef TQVP_CAPTURE_TIMESTAMP_EN
  localparam int ENTRY_W = 16;
`else
  localparam int ENTRY_W = 8;
`endif

  logic               en;
  logic               mode;
  logic [7:0]         div;
  logic [7:0]         div_cnt;
  logic [7:0]         sync1;
  logic [7:0]         sync2;
  logic [7:0]         last_pushed;
  logic               overflow;

  logic               wr_ctrl;
  logic               wr_div;
  logic               wr_data;
  logic               wr_status;
  logic               clr;
  logic               tick;
  logic               push_req;
  logic               fifo_push;
  logic               fifo_pop;
  logic               push_ok;
  logic               ovf_set;
  logic               ovf_clr;

  logic [ENTRY_W-1:0] fifo_din;
  logic [ENTRY_W-1:0] fifo_dout;
  logic [PTR_W:0]     fifo_count;
  logic               fifo_empty;
  logic               fifo_full;
  logic [7:0]         ts_rd;
  logic [7:0]         status;

  assign wr_ctrl   = data_write && (address == ADDR_CTRL);
  assign wr_div    = data_write && (address == ADDR_DIV);
  assign wr_data   = data_write && (address == ADDR_DATA);
  assign wr_status = data_write && (address == ADDR_STATUS);
  assign clr       = wr_ctrl && data_in[CLR_BIT];

  assign tick      = en && (div_cnt == div);
  assign push_req  = tick && (!mode || (sync2 != last_pushed));
  // A flush wins over any coincident FIFO traffic.
  assign fifo_push = push_req && !clr;
  assign fifo_pop  = wr_data && !clr;
  assign push_ok   = fifo_push && (!fifo_full || fifo_pop);
  assign ovf_set   = fifo_push && fifo_full && !fifo_pop;
  assign ovf_clr   = wr_status && data_in[ST_OVF_BIT];

`ifdef TQVP_CAPTURE_TIMESTAMP_EN
  logic [7:0] ts_cnt;

  // Free-running stamp counter; a flush restarts it.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) ts_cnt <= '0;
    else               ts_cnt <= ts_cnt + 1'b1;
  end

  assign fifo_din = {ts_cnt, sync2};
  assign ts_rd    = fifo_dout[15:8];
`else
  assign fifo_din = sync2;
  assign ts_rd    = '0;
`endif

  tqvp_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Control and divider registers written from the bus.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en   <= 1'b0;
      mode <= 1'b0;
      div  <= '0;
    end else begin
      if (wr_ctrl) begin
        en   <= data_in[EN_BIT];
        mode <= data_in[MODE_BIT];
      end
      if (wr_div) div <= data_in;
    end
  end

  // Sample divider: restarts on any reconfiguration and idles while disabled.
  always_ff @(posedge clk) begin
    if (!rst_n || !en || wr_ctrl || wr_div) div_cnt <= '0;
    else if (tick)                          div_cnt <= '0;
    else                                    div_cnt <= div_cnt + 1'b1;
  end

  // Two-flop synchroniser for the asynchronous PMOD input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ui_in;
      sync2 <= sync1;
    end
  end

  // Reference for on-change mode tracks only samples that actually entered the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) last_pushed <= '0;
    else if (push_ok)  last_pushed <= sync2;
  end

  // Sticky overflow; a new drop beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) overflow <= 1'b0;
    else if (ovf_set)  overflow <= 1'b1;
    else if (ovf_clr)  overflow <= 1'b0;
  end

  // STATUS register image.
  always_comb begin
    status               = '0;
    status[3:0]          = 4'(fifo_count);
    status[ST_EMPTY_BIT] = fifo_empty;
    status[ST_FULL_BIT]  = fifo_full;
    status[ST_OVF_BIT]   = overflow;
  end

  // Read mux; unmapped addresses return zero.
  always_comb begin
    data_out = '0;
    case (address)
      ADDR_CTRL:   data_out = {6'b0, mode, en};
      ADDR_DIV:    data_out = div;
      ADDR_DATA:   data_out = fifo_dout[7:0];
      ADDR_STATUS: data_out = status;
      ADDR_TS:     data_out = ts_rd;
      default:     data_out = '0;
    endcase
  end

  // External status pins.
  always_comb begin
    uo_out                = '0;
    uo_out[UO_NEMPTY_BIT] = !fifo_empty;
    uo_out[UO_FULL_BIT]   = fifo_full;
    uo_out[UO_OVF_BIT]    = overflow;
  end

endmodule

// File: tb/tb_tqvp_byte_capture.sv
// tb/tb_tqvp_byte_capture.sv - self-checking bench for tqvp_byte_capture
module tb_tqvp_byte_capture;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int total = 0;
  int bad   = 0;

  tqvp_byte_capture #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ui_in      (ui_in),
    .uo_out     (uo_out),
    .address    (address),
    .data_write (data_write),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  // Reference model: a queue of captured entries plus the programmer-visible registers.
  typedef struct {
    logic [7:0] s;
    logic [7:0] t;
  } ent_t;

  ent_t       q[$];
  bit         m_en, m_mode, m_ovf;
  logic [7:0] m_div, m_s1, m_s2, m_last, m_ts;
  int         m_cnt;

  task automatic model_reset();
    q.delete();
    m_en = 0; m_mode = 0; m_ovf = 0;
    m_div = 0; m_s1 = 0; m_s2 = 0; m_last = 0; m_ts = 0;
    m_cnt = 0;
  endtask

  task automatic model_step();
    bit tick, push, clr, pop, pop_ok, ovf_set;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tick = m_en && (m_cnt == int'(m_div));
    push = tick && (!m_mode || (m_s2 != m_last));
    clr  = data_write && (address == 4'h0) && data_in[2];
    pop  = data_write && (address == 4'h2);
    if (clr) begin
      q.delete();
      m_ovf = 0; m_last = 0; m_ts = 0; m_cnt = 0;
      m_en = data_in[0]; m_mode = data_in[1];
    end else begin
      pop_ok  = pop && (q.size() > 0);
      ovf_set = push && (q.size() == DEPTH) && !pop_ok;
      if (pop_ok) void'(q.pop_front());
      if (push && !ovf_set) begin
        q.push_back('{s: m_s2, t: m_ts});
        m_last = m_s2;
      end
      if (ovf_set) m_ovf = 1;
      else if (data_write && (address == 4'h3) && data_in[6]) m_ovf = 0;
      if (!m_en || (data_write && (address == 4'h0 || address == 4'h1))) m_cnt = 0;
      else if (tick) m_cnt = 0;
      else m_cnt = m_cnt + 1;
      if (data_write && address == 4'h0) begin
        m_en = data_in[0]; m_mode = data_in[1];
      end
      if (data_write && address == 4'h1) m_div = data_in;
      m_ts = m_ts + 8'd1;
    end
    m_s2 = m_s1;
    m_s1 = ui_in;
  endtask

  function automatic logic [7:0] exp_data(input logic [3:0] a);
    logic [7:0] r;
    r = 8'h00;
    case (a)
      4'h0: r = {6'b0, m_mode, m_en};
      4'h1: r = m_div;
      4'h2: r = (q.size() > 0) ? q[0].s : 8'h00;
      4'h3: r = {1'b0, m_ovf, (q.size() == DEPTH), (q.size() == 0), 4'(q.size())};
`ifdef TQVP_CAPTURE_TIMESTAMP_EN
      4'h4: r = (q.size() > 0) ? q[0].t : 8'h00;
`endif
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] exp_uo();
    return {5'b0, m_ovf, (q.size() == DEPTH), (q.size() != 0)};
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_data", data_out, exp_data(address));
    chk("model_uo", uo_out, exp_uo());
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    address = a; data_in = d; data_write = 1'b1;
    cycle();
    data_write = 1'b0;
  endtask

  task automatic peek(input logic [3:0] a, input logic [7:0] e, input string nm);
    address = a; data_write = 1'b0;
    #1;
    chk(nm, data_out, e);
  endtask

  typedef struct {
    logic [3:0] addr;
    logic       we;
    logic [7:0] din;
    logic [7:0] exp_rd;
    logic [7:0] exp_uo;
  } vec_t;

  initial begin
    vec_t       vt[12];
    logic [7:0] seq[5];
    logic [7:0] pp_exp[4];
    logic [7:0] t1, t2;
    int         n;

    vt[0]  = '{4'h0, 1'b0, 8'h00, 8'h00, 8'h00};
    vt[1]  = '{4'h1, 1'b0, 8'h00, 8'h00, 8'h00};
    vt[2]  = '{4'h2, 1'b0, 8'h00, 8'h00, 8'h00};
    vt[3]  = '{4'h3, 1'b0, 8'h00, 8'h10, 8'h00};
    vt[4]  = '{4'h4, 1'b0, 8'h00, 8'h00, 8'h00};
    vt[5]  = '{4'h5, 1'b0, 8'h00, 8'h00, 8'h00};
    vt[6]  = '{4'hF, 1'b0, 8'h00, 8'h00, 8'h00};
    vt[7]  = '{4'h1, 1'b1, 8'h5A, 8'h5A, 8'h00};
    vt[8]  = '{4'h0, 1'b1, 8'h07, 8'h03, 8'h00};
    vt[9]  = '{4'h7, 1'b1, 8'hFF, 8'h00, 8'h00};
    vt[10] = '{4'h0, 1'b1, 8'h00, 8'h00, 8'h00};
    vt[11] = '{4'h3, 1'b1, 8'h40, 8'h10, 8'h00};

    seq[0] = 8'h00; seq[1] = 8'h00; seq[2] = 8'h3C; seq[3] = 8'h3C; seq[4] = 8'hC3;
    pp_exp[0] = 8'h11; pp_exp[1] = 8'h11; pp_exp[2] = 8'h11; pp_exp[3] = 8'h99;

    rst_n = 1'b0; ui_in = 8'h00; address = 4'h0; data_write = 1'b0; data_in = 8'h00;
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;

    // register table: reset values, readback, unmapped addresses
    for (int i = 0; i < 12; i++) begin
      address = vt[i].addr; data_write = vt[i].we; data_in = vt[i].din;
      cycle();
      data_write = 1'b0;
      chk($sformatf("vec%0d_rd", i), data_out, vt[i].exp_rd);
      chk($sformatf("vec%0d_uo", i), uo_out, vt[i].exp_uo);
    end

    // periodic fill with DIV=3, then overflow and its clear
    ui_in = 8'hA5;
    wr(4'h1, 8'h03);
    wr(4'h0, 8'h01);
    address = 4'h3; #1;
    n = 0;
    while (data_out[3:0] != 4'd4 && n < 40) begin cycle(); n++; end
    chk("fill_cycles", 8'(n), 8'd16);
    chk("full_status", data_out, 8'h24);
    chk("full_uo", uo_out, 8'h03);
    n = 0;
    while (!data_out[6] && n < 10) begin cycle(); n++; end
    chk("ovf_status", data_out, 8'h64);
    chk("ovf_uo", uo_out, 8'h07);
    peek(4'h2, 8'hA5, "ovf_head");
    wr(4'h0, 8'h00);
    wr(4'h3, 8'h40);
    peek(4'h3, 8'h24, "ovf_cleared");

    // on-change capture
    ui_in = 8'h00;
    repeat (3) cycle();
    wr(4'h1, 8'h00);
    wr(4'h0, 8'h07);
    for (int i = 0; i < 5; i++) begin ui_in = seq[i]; cycle(); end
    repeat (4) cycle();
    peek(4'h3, 8'h02, "chg_status");
    wr(4'h0, 8'h00);
    peek(4'h2, 8'h3C, "chg_first");
    wr(4'h2, 8'h00);
    peek(4'h2, 8'hC3, "chg_second");
    wr(4'h2, 8'h00);
    peek(4'h2, 8'h00, "chg_empty_data");
    peek(4'h3, 8'h10, "chg_empty_status");

    // full FIFO with a pop coincident with a push tick
    ui_in = 8'h11;
    wr(4'h1, 8'h03);
    wr(4'h0, 8'h05);
    n = 0;
    while (n < 60) begin
      if (q.size() == DEPTH) ui_in = 8'h99;
      if (q.size() == DEPTH && m_cnt == int'(m_div) && m_s2 == 8'h99) break;
      cycle();
      n++;
    end
    chk("pp_reached", 8'(n < 60), 8'd1);
    wr(4'h2, 8'h00);
    wr(4'h0, 8'h00);
    peek(4'h3, 8'h24, "pp_status");
    for (int i = 0; i < 4; i++) begin
      peek(4'h2, pp_exp[i], $sformatf("pp_pop%0d", i));
      wr(4'h2, 8'h00);
    end
    peek(4'h3, 8'h10, "pp_drained");
    wr(4'h2, 8'h00);
    peek(4'h3, 8'h10, "pop_on_empty");

`ifdef TQVP_CAPTURE_TIMESTAMP_EN
    // timestamps five cycles apart, then CLR mid-stream
    wr(4'h1, 8'h04);
    wr(4'h0, 8'h05);
    address = 4'h3; #1;
    n = 0;
    while (data_out[3:0] < 4'd2 && n < 40) begin cycle(); n++; end
    wr(4'h0, 8'h00);
    peek(4'h4, 8'h04, "ts_first");
    t1 = data_out;
    wr(4'h2, 8'h00);
    peek(4'h4, 8'h09, "ts_second");
    t2 = data_out;
    chk("ts_delta", t2 - t1, 8'd5);
    wr(4'h1, 8'h00);
    wr(4'h0, 8'h01);
    repeat (6) cycle();
    wr(4'h0, 8'h05);
    peek(4'h3, 8'h10, "clr_status");
    cycle();
    chk("ts_restart", data_out, 8'h00);
    wr(4'h0, 8'h00);
`else
    t1 = 8'h00; t2 = 8'h00;
    peek(4'h4, t1 | t2, "ts_absent");
`endif

    // randomized traffic against the model, with one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        rst_n = 1'b0; data_write = 1'b0;
        cycle();
        rst_n = 1'b1;
        peek(4'h3, 8'h10, "midrst_status");
        chk("midrst_uo", uo_out, 8'h00);
      end
      address    = 4'($urandom_range(0, 5));
      data_write = ($urandom_range(0, 3) == 0);
      data_in    = 8'($urandom);
      if (address == 4'h0) begin
        data_in[0] = ($urandom_range(0, 4) != 0);
        data_in[2] = ($urandom_range(0, 7) == 0);
      end
      if (address == 4'h1) data_in = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) ui_in = 8'($urandom_range(0, 3));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tqvp_byte_capture.md
Name: tqvp_byte_capture

Overview:
- TinyQV byte peripheral that samples the input PMOD (ui_in) and buffers the samples in a small FIFO for the core to read.
- It is the upstream feed into the core's byte-peripheral bus: the core drains samples through data_out.
- Sampling runs either periodically or on change, paced by a programmable divider.
- Status flags are also driven on uo_out for external observation.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, 2..8.
- PTR_W, $clog2(DEPTH), FIFO pointer width (derived, not overridden).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; synchronous, active-low.
- ui_in  input  8  input PMOD; asynchronous to clk.
- uo_out  output  8  [0]=not empty, [1]=full, [2]=overflow sticky, [7:3]=0.
- address  input  4  register address within the peripheral.
- data_write  input  1  single-cycle write strobe.
- data_in  input  8  write data, valid with data_write.
- data_out  output  8  read data for the current address; combinational from registers.

Behaviour:
- Register map:
  - 0x0 CTRL (RW): [0] EN; [1] MODE (0=periodic, 1=on-change); [2] CLR, write-only, self-clearing, reads 0; [7:3] read 0.
  - 0x1 DIV (RW): sample tick every DIV+1 clk cycles.
  - 0x2 DATA: read returns the FIFO head (0 when empty). Any write pops one entry; data value ignored.
  - 0x3 STATUS (R): [3:0] count, [4] empty, [5] full, [6] overflow. A write with data_in[6]=1 clears overflow.
  - All other addresses read 0; writes to them are ignored.
- Reset values: CTRL=0, DIV=0, FIFO empty (pointers and count 0), overflow=0, sync flops=0, last-pushed=0, divider counter=0. Hence uo_out=0 and data_out=0 at any unlisted address.
- Synchroniser: ui_in passes through a 2-flop synchroniser (sync2). Sampling uses only sync2.
- Divider:
  - Counts 0..DIV; tick asserts when counter==DIV, then the counter returns to 0. DIV=0 gives a tick every cycle.
  - Counter held at 0 while EN=0, and forced to 0 on any write to DIV or CTRL.
- Push request on tick while EN=1:
  - MODE=0: every tick.
  - MODE=1: only when sync2 != last-pushed. last-pushed updates only on an accepted push.
- Latency: a ui_in edge reaches sync2 after 2 clk. A push at clock edge N is readable on DATA/STATUS from edge N onward (registered, next cycle).
- FIFO rules:
  - Push while not full: write at wr_ptr, count+1.
  - Push while full with no pop that cycle: sample dropped, overflow set (sticky).
  - Pop while empty: ignored; count stays 0; no underflow flag.
  - Simultaneous push and pop: both execute, count unchanged. If full, no overflow is raised.
  - Pointers wrap modulo DEPTH.
- CLR (write CTRL with [2]=1): in that same cycle, flush pointers and count, clear overflow, zero the divider counter and zero last-pushed. EN/MODE load from data_in[1:0]. Any push or pop coincident with CLR is discarded.
- Overflow clear and overflow set in the same cycle: set wins.
- Reset mid-operation: all state returns to reset values on the next edge. Partial samples are not preserved.

Optional Feature:
- Macro: TQVP_CAPTURE_TIMESTAMP_EN.
- When defined:
  - Adds an 8-bit free-running cycle counter, reset 0, wrapping 255->0.
  - Each FIFO entry stores {timestamp, sample}. Address 0x4 reads the head entry's timestamp (0 when empty).
  - A pop removes both fields. CLR also zeros the counter.
- When undefined: no counter or extra storage; address 0x4 reads 0.

Decomposition:
- Package tqvp_capture_pkg:
  - Address constants ADDR_CTRL=0, ADDR_DIV=1, ADDR_DATA=2, ADDR_STATUS=3, ADDR_TS=4.
  - CTRL bit indices EN_BIT, MODE_BIT, CLR_BIT; STATUS bit indices.
- One sub-module, tqvp_sync_fifo:
  - Parameters WIDTH, DEPTH; ports push/pop/din/dout/count/empty/full.
  - WIDTH=8, or 16 with timestamps.
  - Divider, synchroniser and register decode stay in the top module.

Test Plan:
- Reset, then read 0x0..0x4 -> all 0; uo_out=0x00.
- CTRL=0x01, DIV=3, ui_in=0xA5 held -> first push ~6 cycles later, then one push every 4 cycles. STATUS count increments to 4 with full=1; uo_out=0x03.
- FIFO full (DEPTH=4), wait one more tick -> overflow=1, uo_out=0x07, head still the oldest sample. Write STATUS with data_in=0x40 -> overflow=0.
- MODE=1, DIV=0; ui_in sequence 0x00, 0x00, 0x3C, 0x3C, 0xC3 -> exactly two entries, 0x3C then 0xC3. Popping via writes to 0x2 reads them in order, then empty=1 and DATA=0.
- Full FIFO, push tick coincident with a pop write -> count stays 4, no overflow, new sample at the tail. Pop on empty -> count stays 0.
- With TQVP_CAPTURE_TIMESTAMP_EN: two pushes 5 cycles apart -> address 0x4 timestamps differ by 5 (mod 256). CLR mid-stream -> count=0, overflow=0, timestamp counter restarts at 0.
